// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - walks an instruction window, executes each entry, streams results; DIV_ZERO_TRAP_EN aborts a run on divide-by-zero
module instr_exec_unit #(
   parameter int ADDR_W = 5,
   parameter int OP_W   = 32,
   parameter int RES_W  = 64,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic [CNT_W-1:0]      count,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     read_pointer,
   input  logic [4+2*OP_W-1:0]   instruction_word,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [RES_W-1:0]      result,
   output logic [3:0]            res_opcode,
   output logic [ADDR_W-1:0]     res_addr,
   output logic                  div_zero
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_OUT   = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   localparam logic [3:0] OP_ZERO  = 4'd0;
   localparam logic [3:0] OP_PASSA = 4'd1;
   localparam logic [3:0] OP_PASSB = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_MULT  = 4'd5;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_MOD   = 4'd7;

   logic [2:0]            state_q, state_d;
   logic [ADDR_W-1:0]     rp_q, rp_d;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic [4+2*OP_W-1:0]   ir_q, ir_d;
   logic [RES_W-1:0]      result_q, result_d;
   logic [3:0]            opcode_q, opcode_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  valid_q, valid_d;
   logic                  dz_q, dz_d;

   logic [3:0]               ir_op;
   logic [OP_W-1:0]          ir_a, ir_b;
   logic signed [RES_W-1:0]  a_x, b_x;
   logic signed [RES_W-1:0]  alu_res;
   logic                     alu_dz;
   logic                     trap_abort;

   assign ir_op = ir_q[4+2*OP_W-1:2*OP_W];
   assign ir_a  = ir_q[2*OP_W-1:OP_W];
   assign ir_b  = ir_q[OP_W-1:0];
   assign a_x   = {{(RES_W-OP_W){ir_a[OP_W-1]}}, ir_a};
   assign b_x   = {{(RES_W-OP_W){ir_b[OP_W-1]}}, ir_b};

`ifdef DIV_ZERO_TRAP_EN
   assign trap_abort = dz_q;
`else
   assign trap_abort = 1'b0;
`endif

   // Operands are widened before the arithmetic so MULT keeps the full product.
   always_comb begin
      alu_res = '0;
      alu_dz  = 1'b0;
      case (ir_op)
         OP_ZERO:  alu_res = '0;
         OP_PASSA: alu_res = a_x;
         OP_PASSB: alu_res = b_x;
         OP_ADD:   alu_res = a_x + b_x;
         OP_SUB:   alu_res = a_x - b_x;
         OP_MULT:  alu_res = a_x * b_x;
         OP_DIV: begin
            if (ir_b == '0) alu_dz = 1'b1;
            else            alu_res = a_x / b_x;
         end
         OP_MOD: begin
            if (ir_b == '0) alu_dz = 1'b1;
            else            alu_res = a_x % b_x;
         end
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      rp_d     = rp_q;
      rem_d    = rem_q;
      ir_d     = ir_q;
      result_d = result_q;
      opcode_d = opcode_q;
      addr_d   = addr_q;
      valid_d  = valid_q;
      dz_d     = dz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (count != '0) begin
                  rp_d    = start_addr;
                  rem_d   = count;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_FETCH: begin
            ir_d    = instruction_word;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            result_d = alu_res;
            dz_d     = alu_dz;
            opcode_d = ir_op;
            addr_d   = rp_q;
            valid_d  = 1'b1;
            state_d  = S_OUT;
         end
         S_OUT: begin
            if (res_ready) begin
               valid_d = 1'b0;
               rem_d   = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1) || trap_abort) begin
                  state_d = S_FIN;
               end else begin
                  rp_d    = rp_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         rp_q     <= '0;
         rem_q    <= '0;
         ir_q     <= '0;
         result_q <= '0;
         opcode_q <= '0;
         addr_q   <= '0;
         valid_q  <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rp_q     <= rp_d;
         rem_q    <= rem_d;
         ir_q     <= ir_d;
         result_q <= result_d;
         opcode_q <= opcode_d;
         addr_q   <= addr_d;
         valid_q  <= valid_d;
         dz_q     <= dz_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_FIN);
   assign read_pointer = rp_q;
   assign res_valid    = valid_q;
   assign result       = result_q;
   assign res_opcode   = opcode_q;
   assign res_addr     = addr_q;
   assign div_zero     = dz_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb/tb_instr_exec_unit.sv - directed self-checking bench for instr_exec_unit
module tb_instr_exec_unit;

   localparam logic [3:0] OP_ZERO  = 4'd0;
   localparam logic [3:0] OP_PASSA = 4'd1;
   localparam logic [3:0] OP_PASSB = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_MULT  = 4'd5;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_MOD   = 4'd7;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [4:0]  start_addr;
   logic [5:0]  count;
   logic        busy;
   logic        done;
   logic [4:0]  read_pointer;
   logic [67:0] instruction_word;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] result;
   logic [3:0]  res_opcode;
   logic [4:0]  res_addr;
   logic        div_zero;

   logic [67:0] mem [32];
   int          n_checks;
   int          n_fail;

   assign instruction_word = mem[read_pointer];

   instr_exec_unit dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .start_addr       (start_addr),
      .count            (count),
      .busy             (busy),
      .done             (done),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .result           (result),
      .res_opcode       (res_opcode),
      .res_addr         (res_addr),
      .div_zero         (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [67:0] mk(input logic [3:0] op, input int a, input int b);
      logic [31:0] av, bv;
      av = a;
      bv = b;
      return {op, av, bv};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic get_res(input string tag, input int exp_lat, input logic [63:0] exp_res,
                          input logic [4:0] exp_addr, input logic [3:0] exp_op, input logic exp_dz);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end while (!res_valid && cyc < 20);
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_res"}, result, exp_res);
      check({tag, "_addr"}, res_addr, exp_addr);
      check({tag, "_op"}, res_opcode, exp_op);
      check({tag, "_dz"}, div_zero, exp_dz);
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end while (!done && cyc < 20);
      check({tag, "_done_lat"}, cyc, exp_lat);
      check({tag, "_done_valid"}, res_valid, 1'b0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   initial begin
      int seen;
      n_checks   = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      count      = '0;
      res_ready  = 1'b1;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      mem[0]  = mk(OP_ADD, 5, 3);
      mem[1]  = mk(OP_SUB, 5, 8);
      mem[2]  = mk(OP_MULT, -7, 6);
      mem[5]  = mk(OP_PASSA, 42, 9);
      mem[8]  = mk(OP_DIV, -7, 2);
      mem[9]  = mk(OP_MOD, -7, 2);
      mem[10] = mk(OP_DIV, 9, 0);
      mem[11] = mk(OP_MOD, 9, 0);
      mem[30] = mk(OP_PASSB, 7, 130);
      mem[31] = mk(OP_PASSB, 7, 131);

      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_valid", res_valid, 1'b0);
      check("rst_dz", div_zero, 1'b0);
      check("rst_rp", read_pointer, 5'd0);
      check("rst_result", result, 64'd0);
      check("rst_opcode", res_opcode, 4'd0);
      check("rst_addr", res_addr, 5'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // basic three-instruction run
      start = 1'b1; start_addr = 5'd0; count = 6'd3;
      get_res("basic0", 3, 64'd8, 5'd0, OP_ADD, 1'b0);
      get_res("basic1", 3, -64'sd3, 5'd1, OP_SUB, 1'b0);
      get_res("basic2", 3, -64'sd42, 5'd2, OP_MULT, 1'b0);
      wait_done("basic", 1);

      // backpressure: five stalled cycles
      res_ready = 1'b0;
      start = 1'b1; start_addr = 5'd5; count = 6'd1;
      get_res("bp", 3, 64'd42, 5'd5, OP_PASSA, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("bp_hold_valid", res_valid, 1'b1);
         check("bp_hold_result", result, 64'd42);
      end
      check("bp_no_done", done, 1'b0);
      res_ready = 1'b1;
      wait_done("bp", 1);

      // read pointer wrap
      start = 1'b1; start_addr = 5'd30; count = 6'd4;
      get_res("wrap0", 3, 64'd130, 5'd30, OP_PASSB, 1'b0);
      get_res("wrap1", 3, 64'd131, 5'd31, OP_PASSB, 1'b0);
      get_res("wrap2", 3, 64'd8, 5'd0, OP_ADD, 1'b0);
      get_res("wrap3", 3, -64'sd3, 5'd1, OP_SUB, 1'b0);
      wait_done("wrap", 1);

      // signed division edges and divide by zero
      start = 1'b1; start_addr = 5'd8; count = 6'd4;
      get_res("div0", 3, -64'sd3, 5'd8, OP_DIV, 1'b0);
      get_res("div1", 3, -64'sd1, 5'd9, OP_MOD, 1'b0);
      get_res("div2", 3, 64'd0, 5'd10, OP_DIV, 1'b1);
`ifdef DIV_ZERO_TRAP_EN
      wait_done("div_trap", 1);
`else
      get_res("div3", 3, 64'd0, 5'd11, OP_MOD, 1'b1);
      wait_done("div", 1);
`endif

      // zero count, with a start in the done cycle that must be ignored
      start = 1'b1; start_addr = 5'd3; count = 6'd0;
      @(negedge clk);
      check("zc_done", done, 1'b1);
      check("zc_valid", res_valid, 1'b0);
      start = 1'b1; start_addr = 5'd5; count = 6'd1;
      @(negedge clk);
      start = 1'b0;
      check("zc_done_clear", done, 1'b0);
      check("zc_start_ignored", busy, 1'b0);

      // start while busy is ignored
      start = 1'b1; start_addr = 5'd0; count = 6'd2;
      @(negedge clk);
      check("ov_busy", busy, 1'b1);
      start = 1'b1; start_addr = 5'd20; count = 6'd0;
      get_res("ov0", 2, 64'd8, 5'd0, OP_ADD, 1'b0);
      get_res("ov1", 3, -64'sd3, 5'd1, OP_SUB, 1'b0);
      wait_done("ov", 1);

      // asynchronous reset mid-run while a result is pending
      res_ready = 1'b0;
      start = 1'b1; start_addr = 5'd5; count = 6'd3;
      get_res("ar", 3, 64'd42, 5'd5, OP_PASSA, 1'b0);
      reset_n = 1'b0;
      #1;
      check("ar_valid", res_valid, 1'b0);
      check("ar_busy", busy, 1'b0);
      check("ar_done", done, 1'b0);
      check("ar_rp", read_pointer, 5'd0);
      check("ar_result", result, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      res_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy || res_valid) seen++;
      end
      check("ar_quiet_after", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Downstream consumer of instr_register.
- Walks read_pointer over a programmed window of stored instructions and samples instruction_word.
- Computes each result: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD.
- Presents each result on a valid/ready output channel toward the checker or writeback side.

Parameters:
- ADDR_W, 5, read_pointer/address width (register depth 2**ADDR_W = 32).
- OP_W, 32, signed operand width.
- RES_W, 64, signed result width (holds full MULT product).
- CNT_W, 6, width of count input (max 32 instructions per run).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle request to begin a run; sampled only in IDLE.
- start_addr  input  ADDR_W  first address of run.
- count  input  CNT_W  instructions in run; 0 = immediate done, no results.
- busy  output  1  high from cycle after accepted start until done.
- done  output  1  1-cycle pulse at end of run.
- read_pointer  output  ADDR_W  address driven to instr_register.
- instruction_word  input  4+2*OP_W  {opcode[67:64], op_a[63:32], op_b[31:0]}; combinational read of read_pointer.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result when res_valid & res_ready.
- result  output  RES_W  signed result.
- res_opcode  output  4  opcode of the result.
- res_addr  output  ADDR_W  source address of the result.
- div_zero  output  1  result came from DIV/MOD with op_b == 0.

Behaviour:
- Reset (async assert, sync release): state IDLE. busy, done, res_valid, div_zero = 0. read_pointer, result, res_opcode, res_addr = 0. Internal remaining-count = 0.
- FSM states: IDLE, FETCH, EXEC, OUT, FIN.
- IDLE:
  - start=1, count>0: latch read_pointer = start_addr and remaining = count; go to FETCH.
  - start=1, count=0: go to FIN.
  - start=0: stay.
- FETCH: register instruction_word into an internal IR; go to EXEC. One cycle; read_pointer is stable throughout.
- EXEC: compute from IR, with operands sign-extended to RES_W.
  - ZERO → 0. PASSA → a. PASSB → b.
  - ADD → a+b. SUB → a−b. MULT → a*b (full 64-bit signed).
  - DIV → a/b, truncated toward zero. MOD → a%b, sign follows a.
  - Opcode values 8–15 → 0.
  - DIV/MOD with b==0 → result 0, div_zero=1; otherwise div_zero=0.
  - Register result, res_opcode, res_addr=read_pointer; set res_valid=1; go to OUT.
- OUT:
  - Hold result and res_valid until res_ready=1. Outputs stable while stalled.
  - On handshake: res_valid drops next cycle and remaining decrements.
  - remaining was 1 → FIN.
  - Otherwise read_pointer increments modulo 2**ADDR_W (31 → 0 wrap) → FETCH.
- FIN: done=1 for exactly one cycle; busy=0 next cycle; go to IDLE.
- Latency: start to first res_valid = 3 cycles (IDLE→FETCH→EXEC→OUT). Back-to-back throughput with res_ready held high is 1 result per 3 cycles.
- start while busy is ignored. start in the same cycle as done is ignored.
- res_ready while res_valid=0 has no effect.
- Reset asserted mid-run: immediate abort, all outputs to reset values, no done pulse.
- instruction_word is sampled only in FETCH. Changes in other cycles are ignored.

Optional Feature:
- Macro DIV_ZERO_TRAP_EN.
- Defined: a DIV/MOD with b==0 presents its result (div_zero=1) in OUT. After that handshake the run aborts regardless of remaining: go to FIN, done pulses, no further fetches.
- Not defined: div_zero result is presented and the run continues normally.

Test Plan:
- Reset: hold reset_n=0 mid-run at res_valid=1 → res_valid, busy, done, read_pointer all 0 same cycle; no done afterwards.
- Basic run: entries 0–2 = {ADD,5,3}, {SUB,5,8}, {MULT,−7,6}, start_addr=0, count=3, res_ready=1 → results 8, −3, −42 with res_addr 0,1,2; first res_valid 3 cycles after start; done once.
- Backpressure: count=1, {PASSA,42,9}, res_ready=0 for 5 cycles → res_valid and result=42 held stable 5 cycles; done 1 cycle after handshake.
- Wrap: start_addr=30, count=4 → res_addr sequence 30, 31, 0, 1.
- Div edge: {DIV,−7,2}, {MOD,−7,2}, {DIV,9,0}, {MOD,9,0}, count=4 → −3, −1, 0 (div_zero=1), 0 (div_zero=1). With DIV_ZERO_TRAP_EN only three results appear and done follows the third.
- Zero count and overlap: count=0 → done 1 cycle later, no res_valid; start pulsed again while busy → ignored, run unaffected.
